reg_bank: RTL and testbench
===========================

# reg_bank

Parametrised multi-port general-purpose register file for the single-cycle CPU datapath, successor to the fixed 32x32 two-read/one-write file. Writes are clocked on the rising edge of `clk`, and reads are combinational. The block provides N read ports, two prioritised write ports, an optional hardwired zero register, optional write-to-read bypass, and a sequenced soft-clear engine with a busy flag. It sits between the decode stage (addresses) and the ALU/writeback mux (data).

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; DEPTH = 2**ADDR_W registers
- `NUM_RD`, 2, number of read ports (1..4)
- `ZERO_REG`, 1, 1 = register 0 always reads 0 and ignores writes
- `BYPASS`, 1, 1 = a read of an address being written this cycle returns the new write data

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_en`  in  2  per-port write enable; bit p belongs to write port p
- `wr_addr`  in  2*ADDR_W  write addresses; port p in bits [p*ADDR_W +: ADDR_W]
- `wr_data`  in  2*DATA_W  write data; port p in bits [p*DATA_W +: DATA_W]
- `rd_addr`  in  NUM_RD*ADDR_W  read addresses, packed the same way
- `rd_data`  out  NUM_RD*DATA_W  read data, packed the same way; combinational
- `clr`  in  1  single-cycle request to zero the whole file sequentially
- `busy`  out  1  high while the clear sequence runs

## Operation
- Storage: DEPTH x DATA_W flops.
- Reset (`rst_n`=0):
  - all registers go to 0 immediately (asynchronously);
  - `busy`=0 and the clear index is 0;
  - every `rd_data` lane reads 0.
- Write: on a rising edge with `busy`=0, each port p with `wr_en[p]`=1 stores its `wr_data` slice at its `wr_addr` slice.
- Write collision: if both ports write the same address in one cycle, port 1 wins and the port 0 data is discarded.
- Zero register (`ZERO_REG`=1): writes to address 0 are dropped, and reads of address 0 return 0 on every port, including on bypass.
- Read: `rd_data` lane r = storage[`rd_addr` lane r], combinational.
- Bypass (`BYPASS`=1): if an accepted write this cycle targets the address on lane r, lane r returns that write's data, using port 1's data on a collision.
  - A write is accepted when `wr_en`=1, `busy`=0, and the address is not a dropped zero-register write.
- No bypass (`BYPASS`=0): new data appears on reads only in the cycle after the write edge.
- Clear state machine, two states:
  - IDLE → CLEAR: on a rising edge with `clr`=1 and state IDLE. The index is loaded with 0 and `busy` goes to 1 after that edge.
  - In CLEAR: each edge writes 0 to storage[index] and increments index.
  - CLEAR → IDLE: on the edge that clears index DEPTH-1. `busy` goes to 0 after that edge, and the index wraps to 0.
- While busy:
  - `clr` is ignored; the clear is not restarted.
  - Both write ports are ignored and their data is lost; the CPU must stall on `busy`.
  - Reads return current storage, so partially cleared state is visible and deterministic. No bypass occurs, because no writes are accepted.
- `rst_n` asserted mid-clear aborts it: all registers become 0, state returns to IDLE, and `busy`=0.

## Timing
- Write latency: 1 edge into storage; 0 cycles to the read port with `BYPASS`=1.
- Clear duration: `busy` is high for exactly DEPTH cycles (32 at the defaults), starting the cycle after the edge that samples `clr`.
- A write presented in the same cycle as a `clr` sampled from IDLE is accepted, because `busy` is still 0 in that cycle. The clear then zeroes that register when the index reaches it.
- Read-path delay: address mux plus bypass compare; there is no register stage on any read lane.
- Reset release: fully synchronous behaviour from the first rising edge after `rst_n` goes high.

## Test plan
- Reset then basic write/read:
  - Release reset. Write 0xDEADBEEF to r5 via port 0.
  - Next cycle, read lane 0 = r5 → 0xDEADBEEF. Lane 1 = r6 → 0x00000000.
- Dual write and collision:
  - Same cycle: port 0 writes r7=0x11111111 and port 1 writes r8=0x22222222. Next cycle r7/r8 read back those values.
  - Then both ports write r9, port 0 with 0xAAAA0000 and port 1 with 0x0000BBBB. Next cycle r9 = 0x0000BBBB.
- Zero register and bypass:
  - Port 0 writes r0=0xFFFFFFFF → r0 reads 0 in the same cycle and the next.
  - Port 1 writes r3=0x12345678 while lane 1 reads r3 in the same cycle → lane 1 = 0x12345678 before the edge (`BYPASS`=1).
  - With `BYPASS`=0, the same stimulus shows the old value (0) until after the edge.
- Soft clear:
  - Fill r1..r31 with nonzero values, then pulse `clr` for 1 cycle.
  - `busy` stays high for 32 cycles. After 2 busy cycles, r1 = 0 and r2 still holds its value. After `busy` falls, all registers read 0.
- Writes and clr while busy:
  - During the clear, port 0 writes r10=0x55555555 and `clr` is pulsed again. The write is lost (r10 = 0 after the clear) and `busy` still falls at exactly 32 cycles.
- Reset mid-clear:
  - Assert `rst_n`=0 at clear index 12. `busy` drops immediately and all registers read 0.
  - A write after release works normally.

Source files
------------

// File: rtl/reg_bank.sv
// reg_bank: parametrised multi-port register file with two prioritised write
// ports, an optional hardwired zero register, optional write-to-read bypass and
// a sequenced soft-clear engine.
//
// Ports:
//   clk      - clock; all state updates on the rising edge
//   rst_n    - asynchronous active-low reset; zeroes storage, aborts a clear
//   wr_en    - per-port write enable (bit p -> write port p)
//   wr_addr  - write addresses, port p in [p*ADDR_W +: ADDR_W]
//   wr_data  - write data, port p in [p*DATA_W +: DATA_W]
//   rd_addr  - read addresses, lane r in [r*ADDR_W +: ADDR_W]
//   rd_data  - combinational read data, lane r in [r*DATA_W +: DATA_W]
//   clr      - single-cycle request to zero the whole file, one entry per cycle
//   busy     - high while the clear sequence runs; writes are dropped meanwhile
module reg_bank #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 wr_en,
    input  logic [2*ADDR_W-1:0]        wr_addr,
    input  logic [2*DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       clr,
    output logic                       busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {StIdle, StClear} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];

    logic [ADDR_W-1:0]   wa [2];
    logic [DATA_W-1:0]   wd [2];
    logic [1:0]          wr_acc;

    assign busy = (state_q == StClear);

    for (genvar p = 0; p < 2; p++) begin : g_wr
        assign wa[p] = wr_addr[p*ADDR_W +: ADDR_W];
        assign wd[p] = wr_data[p*DATA_W +: DATA_W];
        // Accepted writes only: not busy and not a dropped zero-register write.
        assign wr_acc[p] = wr_en[p] && !busy && !((ZERO_REG != 0) && (wa[p] == '0));
    end

    // Clear sequencer: index walks 0..DEPTH-1, one entry per edge.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            StIdle: begin
                if (clr) begin
                    state_d   = StClear;
                    clr_idx_d = '0;
                end
            end
            StClear: begin
                clr_idx_d = clr_idx_q + ADDR_W'(1);
                if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Storage next state; port 1 is applied last so it wins a collision.
    always_comb begin
        mem_d = mem_q;
        if (busy) begin
            mem_d[clr_idx_q] = '0;
        end else begin
            if (wr_acc[0]) mem_d[wa[0]] = wd[0];
            if (wr_acc[1]) mem_d[wa[1]] = wd[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            clr_idx_q <= '0;
            mem_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            mem_q     <= mem_d;
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;

        assign ra = rd_addr[r*ADDR_W +: ADDR_W];

        always_comb begin
            rv = mem_q[ra];
            if (BYPASS != 0) begin
                if (wr_acc[0] && (wa[0] == ra)) rv = wd[0];
                if (wr_acc[1] && (wa[1] == ra)) rv = wd[1];
            end
            if ((ZERO_REG != 0) && (ra == '0)) rv = '0;
            // Lanes read zero throughout reset, whatever the write inputs do.
            if (!rst_n) rv = '0;
        end

        assign rd_data[r*DATA_W +: DATA_W] = rv;
    end

endmodule

// File: tb/tb_reg_bank.sv
module tb_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data_nb;
    logic        clr;
    logic        busy, busy_nb;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_bank #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .clr(clr), .busy(busy)
    );

    reg_bank #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_nb), .clr(clr), .busy(busy_nb)
    );

    // Reference model: plain array plus a countdown of remaining clear cycles.
    logic [31:0] model [32];
    int          clr_left;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = '0;
        clr_left = 0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        logic [31:0] v;
        v = model[a];
        if (byp && clr_left == 0) begin
            if (wr_en[0] && wr_addr[4:0] == a) v = wr_data[31:0];
            if (wr_en[1] && wr_addr[9:5] == a) v = wr_data[63:32];
        end
        if (a == 5'd0) v = '0;
        return v;
    endfunction

    task automatic check_model();
        logic [4:0] ra;
        for (int l = 0; l < 2; l++) begin
            ra = rd_addr[l*5 +: 5];
            chk($sformatf("rd_byp_lane%0d_r%0d", l, ra), rd_data[l*32 +: 32], exp_rd(ra, 1'b1));
            chk($sformatf("rd_nobyp_lane%0d_r%0d", l, ra), rd_data_nb[l*32 +: 32],
                exp_rd(ra, 1'b0));
        end
        chk("busy", 32'(busy), 32'(clr_left > 0));
        chk("busy_nb", 32'(busy_nb), 32'(clr_left > 0));
    endtask

    task automatic edge_step();
        @(posedge clk);
        if (clr_left > 0) begin
            model[32 - clr_left] = '0;
            clr_left--;
        end else begin
            if (wr_en[0] && wr_addr[4:0] != 5'd0) model[wr_addr[4:0]] = wr_data[31:0];
            if (wr_en[1] && wr_addr[9:5] != 5'd0) model[wr_addr[9:5]] = wr_data[63:32];
            if (clr) clr_left = 32;
        end
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
        check_model();
        edge_step();
    endtask

    task automatic idle_inputs();
        wr_en = 2'b00; clr = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0, e1;   // BYPASS=1 expected lanes (before the edge)
        logic [31:0] n0, n1;   // BYPASS=0 expected lanes (before the edge)
    } vec_t;

    vec_t tbl [9];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit s_busy;

        tbl[0] = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd5, 5'd6,
                   32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
        tbl[1] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd6,
                   32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
        tbl[2] = '{2'b11, 5'd7, 32'h11111111, 5'd8, 32'h22222222, 5'd7, 5'd8,
                   32'h11111111, 32'h22222222, 32'h0, 32'h0};
        tbl[3] = '{2'b11, 5'd9, 32'hAAAA0000, 5'd9, 32'h0000BBBB, 5'd7, 5'd8,
                   32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222};
        tbl[4] = '{2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 5'd9, 5'd0,
                   32'h0000BBBB, 32'h0, 32'h0000BBBB, 32'h0};
        tbl[5] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd9,
                   32'h0, 32'h0000BBBB, 32'h0, 32'h0000BBBB};
        tbl[6] = '{2'b10, 5'd0, 32'h0, 5'd3, 32'h12345678, 5'd5, 5'd3,
                   32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h0};
        tbl[7] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd3,
                   32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
        tbl[8] = '{2'b11, 5'd9, 32'h00000001, 5'd9, 32'h00000002, 5'd9, 5'd9,
                   32'h00000002, 32'h00000002, 32'h0000BBBB, 32'h0000BBBB};

        // Reset state, with write inputs active to show lanes stay zero.
        rst_n = 1'b0; clr = 1'b0;
        wr_en = 2'b11; wr_addr = {5'd6, 5'd5}; wr_data = {32'h1, 32'h2}; rd_addr = {5'd6, 5'd5};
        model_reset();
        #3;
        chk("reset_rd0", rd_data[31:0], 32'h0);
        chk("reset_rd1", rd_data[63:32], 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            wr_en   = tbl[i].we;
            wr_addr = {tbl[i].wa1, tbl[i].wa0};
            wr_data = {tbl[i].wd1, tbl[i].wd0};
            rd_addr = {tbl[i].ra1, tbl[i].ra0};
            @(negedge clk);
            chk($sformatf("tbl%0d_byp_l0", i), rd_data[31:0], tbl[i].e0);
            chk($sformatf("tbl%0d_byp_l1", i), rd_data[63:32], tbl[i].e1);
            chk($sformatf("tbl%0d_nb_l0", i), rd_data_nb[31:0], tbl[i].n0);
            chk($sformatf("tbl%0d_nb_l1", i), rd_data_nb[63:32], tbl[i].n1);
            check_model();
            edge_step();
        end
        idle_inputs();

        // Randomised traffic including occasional clears and writes while busy.
        for (int i = 0; i < 400; i++) begin
            wr_en   = 2'($urandom_range(0, 3));
            wr_addr = 10'($urandom);
            wr_data = {$urandom, $urandom};
            rd_addr = 10'($urandom);
            clr     = ($urandom_range(0, 59) == 0);
            cyc();
        end
        idle_inputs();
        for (int i = 0; i < 40 && clr_left > 0; i++) cyc();

        // Soft clear with a lost write and an ignored second clr mid-sequence.
        for (int i = 1; i < 32; i++) begin
            wr_en = 2'b01; wr_addr = {5'd0, 5'(i)}; wr_data = {32'h0, 32'hA5000000 + 32'(i)};
            cyc();
        end
        idle_inputs();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            rd_addr = {5'd2, 5'd1};
            if (k == 5) begin
                wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'h0, 32'h55555555};
                clr = 1'b1;
            end else begin
                idle_inputs();
            end
            @(negedge clk);
            s_busy = busy;
            if (k == 2) begin
                chk("clr_r1_zero", rd_data[31:0], 32'h0);
                chk("clr_r2_held", rd_data[63:32], 32'hA5000002);
            end
            check_model();
            edge_step();
            if (s_busy) n++;
            else break;
        end
        idle_inputs();
        chk("busy_len", 32'(n), 32'd32);
        for (int i = 0; i < 32; i += 2) begin
            rd_addr = {5'(i + 1), 5'(i)};
            @(negedge clk);
            chk($sformatf("cleared_r%0d", i), rd_data[31:0], 32'h0);
            chk($sformatf("cleared_r%0d", i + 1), rd_data[63:32], 32'h0);
            edge_step();
        end

        // Reset in the middle of a clear.
        wr_en = 2'b01; wr_addr = {5'd0, 5'd20}; wr_data = {32'h0, 32'h00000077};
        cyc();
        idle_inputs();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        for (int i = 0; i < 12; i++) cyc();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midclr_busy", 32'(busy), 32'h0);
        chk("midclr_busy_nb", 32'(busy_nb), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_addr = {5'd31, 5'd20};
        #1;
        chk("post_rst_r20", rd_data[31:0], 32'h0);
        chk("post_rst_r31", rd_data[63:32], 32'h0);
        @(posedge clk); #1;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd20}; wr_data = {32'h0, 32'hCAFEF00D};
        cyc();
        idle_inputs();
        @(negedge clk);
        chk("post_rst_write", rd_data_nb[31:0], 32'hCAFEF00D);
        check_model();
        edge_step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
